// File: rtl/dcls_pkg.sv
// Shared types and timing helpers for the DCLS comparator self-test scheduler.
package dcls_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TEST  = 2'd1,
    CLEAR = 2'd2
  } state_e;

  // Redundant error pair as driven by one comparator instance.
  typedef struct packed {
    logic err;
    logic err_b;
  } dcls_pair_t;

  // Comparator flag latency: OR-tree stages plus the output flop.
  function automatic int unsigned lat_cyc(input int unsigned nos);
    return nos + 1;
  endfunction

  // Test window: walk every data bit on both rails, then let the flag settle.
  function automatic int unsigned test_cyc(input int unsigned dw, input int unsigned nos);
    return 2 * dw + lat_cyc(nos) + 1;
  endfunction

  // Disable window long enough to drain the OR pipeline and drop the sticky flag.
  function automatic int unsigned clr_cyc(input int unsigned nos);
    return lat_cyc(nos) + 1;
  endfunction

endpackage

// File: rtl/dcls_err_monitor.sv
// Per-channel sticky run-time error detector for one comparator error pair.
module dcls_err_monitor
  import dcls_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       mon_en,
  input  logic       mask,
  input  logic       clr,
  input  dcls_pair_t pair,
  output logic       run_err
);

  logic set_evt;

  // Only (err=0, err_b=1) is a healthy, consistent pair; anything else is flagged.
  assign set_evt = mon_en & ~mask & (pair.err | ~pair.err_b);

  // Sticky flag; a new event in the clear cycle wins over the clear.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) run_err <= 1'b0;
    else         run_err <= set_evt | (run_err & ~clr);
  end

endmodule

// File: rtl/dcls_bist_scheduler.sv
// Round-robin self-test sequencer and run-time monitor for NUM_CH DCLS comparators.
module dcls_bist_scheduler
  import dcls_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_OR_STAGES = 0,
  parameter int PERIOD_W      = 16,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                ENABLE,
  input  logic                START,
  input  logic [PERIOD_W-1:0] PERIOD,
  input  logic                CLR_STATUS,
  input  logic [NUM_CH-1:0]   ERR_DCLS,
  input  logic [NUM_CH-1:0]   ERR_DCLS_B,
  output logic [NUM_CH-1:0]   ENERR_DCLS,
  output logic [NUM_CH-1:0]   FIERR_DCLS,
  output logic                BIST_BUSY,
  output logic                BIST_DONE,
  output logic [CH_W-1:0]     CUR_CH,
  output logic [NUM_CH-1:0]   BIST_FAIL,
  output logic [NUM_CH-1:0]   RUN_ERR,
  output logic                ALARM
);

  localparam int TEST_CYC = int'(test_cyc(DATA_WIDTH, NUM_OR_STAGES));
  localparam int CLR_CYC  = int'(clr_cyc(NUM_OR_STAGES));
  localparam int CNT_W    = $clog2(TEST_CYC + 1);
  localparam int EN_W     = $clog2(CLR_CYC + 1);

  localparam logic [CNT_W-1:0] TEST_LAST = CNT_W'(TEST_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_CYC - 1);
  localparam logic [EN_W-1:0]  EN_SETTLE = EN_W'(CLR_CYC);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic [PERIOD_W-1:0] per_cnt;
  logic [EN_W-1:0]     en_cnt;
  logic                aborted;

  logic [NUM_CH-1:0]   cur_oh, nxt_oh, all_en, mon_mask, fail_set;
  logic                start_req, mon_en, test_last;

  assign cur_oh = NUM_CH'(1) << CUR_CH;
  assign nxt_oh = NUM_CH'(1) << (CUR_CH + 1'b1);
  assign all_en = {NUM_CH{ENABLE}};

  // Software request or period expiry; coincident triggers collapse into one sweep.
  assign start_req = ENABLE & (START |
                     ((PERIOD != '0) &&
                      (({1'b0, per_cnt} + (PERIOD_W+1)'(1)) >= {1'b0, PERIOD})));

  // Comparators need CLR_CYC enabled cycles before their flags mean anything.
  assign mon_en   = ENABLE & (en_cnt == EN_SETTLE);
  assign mon_mask = (state != IDLE) ? cur_oh : '0;

  // Result sample point: last cycle of an un-aborted test window.
  assign test_last = (state == TEST) & ENABLE & (cnt == TEST_LAST);
  assign fail_set  = (test_last && !(ERR_DCLS[CUR_CH] && !ERR_DCLS_B[CUR_CH])) ? cur_oh : '0;

  // Count consecutive enabled cycles, saturating at the settle time.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)              en_cnt <= '0;
    else if (!ENABLE)         en_cnt <= '0;
    else if (en_cnt != EN_SETTLE) en_cnt <= en_cnt + 1'b1;
  end

  // Sweep sequencer: IDLE -> (TEST -> CLEAR) per channel -> IDLE.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state      <= IDLE;
      cnt        <= '0;
      per_cnt    <= '0;
      aborted    <= 1'b0;
      CUR_CH     <= '0;
      FIERR_DCLS <= '0;
      ENERR_DCLS <= '0;
      BIST_BUSY  <= 1'b0;
      BIST_DONE  <= 1'b0;
    end else begin
      BIST_DONE  <= 1'b0;
      ENERR_DCLS <= all_en;
      case (state)
        IDLE: begin
          if (start_req) begin
            state      <= TEST;
            cnt        <= '0;
            per_cnt    <= '0;
            aborted    <= 1'b0;
            CUR_CH     <= '0;
            FIERR_DCLS <= NUM_CH'(1);
            BIST_BUSY  <= 1'b1;
          end else if (ENABLE && (PERIOD != '0)) begin
            per_cnt <= per_cnt + 1'b1;
          end else begin
            per_cnt <= '0;
          end
        end
        TEST: begin
          if (!ENABLE) begin
            // Abort: drop injection now, still flush this channel.
            state      <= CLEAR;
            cnt        <= '0;
            aborted    <= 1'b1;
            FIERR_DCLS <= '0;
          end else if (cnt == TEST_LAST) begin
            state      <= CLEAR;
            cnt        <= '0;
            FIERR_DCLS <= '0;
            ENERR_DCLS <= all_en & ~cur_oh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == CLR_LAST) begin
            if (aborted || !ENABLE || (CUR_CH == LAST_CH)) begin
              state     <= IDLE;
              cnt       <= '0;
              CUR_CH    <= '0;
              BIST_BUSY <= 1'b0;
              BIST_DONE <= ~aborted & ENABLE;
            end else begin
              state      <= TEST;
              cnt        <= '0;
              CUR_CH     <= CUR_CH + 1'b1;
              FIERR_DCLS <= nxt_oh;
            end
          end else begin
            cnt        <= cnt + 1'b1;
            aborted    <= aborted | ~ENABLE;
            ENERR_DCLS <= all_en & ~cur_oh;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky self-test failures and the aggregated alarm one cycle behind them.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      BIST_FAIL <= '0;
      ALARM     <= 1'b0;
    end else begin
      BIST_FAIL <= fail_set | (BIST_FAIL & ~{NUM_CH{CLR_STATUS}});
      ALARM     <= ((|BIST_FAIL) | (|RUN_ERR)) & ~CLR_STATUS;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_mon
    dcls_pair_t pair;
    assign pair.err   = ERR_DCLS[g];
    assign pair.err_b = ERR_DCLS_B[g];

    dcls_err_monitor u_mon (
      .CLK     (CLK),
      .RESETN  (RESETN),
      .mon_en  (mon_en),
      .mask    (mon_mask[g]),
      .clr     (CLR_STATUS),
      .pair    (pair),
      .run_err (RUN_ERR[g])
    );
  end

endmodule

// File: tb/tb_dcls_bist_scheduler.sv
// Bench: timeline-indexed reference model, directed scenarios plus randomized traffic.
module tb_dcls_bist_scheduler;

  localparam int NUM_CH = 2, DW = 8, NOS = 0, PW = 16;
  localparam int TC = 2 * DW + (NOS + 1) + 1;  // 18
  localparam int CC = (NOS + 1) + 1;           // 2
  localparam int SL = TC + CC;                 // cycles per channel slot

  logic              CLK = 1'b0;
  logic              RESETN, ENABLE, START, CLR_STATUS;
  logic [PW-1:0]     PERIOD;
  logic [NUM_CH-1:0] ERR_DCLS, ERR_DCLS_B;
  logic [NUM_CH-1:0] ENERR_DCLS, FIERR_DCLS, BIST_FAIL, RUN_ERR;
  logic              BIST_BUSY, BIST_DONE, ALARM;
  logic [0:0]        CUR_CH;

  int vectors = 0, miscompares = 0;

  // Reference model: k = index of the current cycle within a sweep, -1 when idle.
  int  k = -1, idle_cnt = 0, en_hist = 0;
  bit  aborted, en_q, m_done, m_alarm;
  bit [1:0] m_fail, m_run;

  // Stimulus control for the comparator stand-ins.
  bit [1:0] stuck, force_en, force_err, force_errb;
  int noise_pct = 0;

  dcls_bist_scheduler #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .NUM_OR_STAGES(NOS), .PERIOD_W(PW)) dut (
    .CLK(CLK), .RESETN(RESETN), .ENABLE(ENABLE), .START(START), .PERIOD(PERIOD),
    .CLR_STATUS(CLR_STATUS), .ERR_DCLS(ERR_DCLS), .ERR_DCLS_B(ERR_DCLS_B),
    .ENERR_DCLS(ENERR_DCLS), .FIERR_DCLS(FIERR_DCLS), .BIST_BUSY(BIST_BUSY),
    .BIST_DONE(BIST_DONE), .CUR_CH(CUR_CH), .BIST_FAIL(BIST_FAIL), .RUN_ERR(RUN_ERR),
    .ALARM(ALARM)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [1:0] oh(input int c);
    bit [1:0] r;
    r = 2'b01;
    return r << c;
  endfunction

  task automatic model_reset();
    k = -1; idle_cnt = 0; en_hist = 0; aborted = 0; en_q = 0;
    m_done = 0; m_alarm = 0; m_fail = '0; m_run = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit mon_ok;
    bit [1:0] fset, rset;
    int ch, ph;
    mon_ok = ENABLE && (en_hist >= CC);
    en_hist = ENABLE ? ((en_hist < CC) ? en_hist + 1 : en_hist) : 0;
    fset = '0; rset = '0; m_done = 0;
    ch = (k >= 0) ? k / SL : -1;
    ph = (k >= 0) ? k % SL : 0;
    for (int i = 0; i < NUM_CH; i++)
      if (mon_ok && !(k >= 0 && i == ch) && (ERR_DCLS[i] || !ERR_DCLS_B[i])) rset[i] = 1'b1;
    if (k < 0) begin
      if (ENABLE && (START || (PERIOD != 0 && idle_cnt + 1 >= int'(PERIOD)))) begin
        k = 0; aborted = 0; idle_cnt = 0;
      end else begin
        idle_cnt = (ENABLE && PERIOD != 0) ? idle_cnt + 1 : 0;
      end
    end else begin
      idle_cnt = 0;
      if (ph < TC) begin
        if (!ENABLE) begin
          aborted = 1; k = ch * SL + TC;
        end else begin
          if (ph == TC - 1 && !(ERR_DCLS[ch] && !ERR_DCLS_B[ch])) fset[ch] = 1'b1;
          k++;
        end
      end else begin
        if (!ENABLE) aborted = 1;
        if (ph == SL - 1 && (aborted || ch == NUM_CH - 1)) begin
          m_done = !aborted; k = -1;
        end else begin
          k++;
        end
      end
    end
    m_alarm = ((|m_fail) || (|m_run)) && !CLR_STATUS;
    m_fail  = fset | (m_fail & ~{2{CLR_STATUS}});
    m_run   = rset | (m_run & ~{2{CLR_STATUS}});
    en_q    = ENABLE;
  endtask

  task automatic check_all(input string where);
    bit busy, in_test;
    int ch;
    bit [1:0] e_fi, e_en;
    busy    = (k >= 0);
    ch      = busy ? k / SL : 0;
    in_test = busy && (k % SL) < TC;
    e_fi    = in_test ? oh(ch) : 2'b00;
    e_en    = {en_q, en_q} & ~((busy && !in_test) ? oh(ch) : 2'b00);
    chk({where, ".FIERR"}, 32'(FIERR_DCLS), 32'(e_fi));
    chk({where, ".ENERR"}, 32'(ENERR_DCLS), 32'(e_en));
    chk({where, ".BUSY"},  32'(BIST_BUSY),  32'(busy));
    chk({where, ".DONE"},  32'(BIST_DONE),  32'(m_done));
    chk({where, ".CUR"},   32'(CUR_CH),     32'(ch));
    chk({where, ".FAIL"},  32'(BIST_FAIL),  32'(m_fail));
    chk({where, ".RUN"},   32'(RUN_ERR),    32'(m_run));
    chk({where, ".ALARM"}, 32'(ALARM),      32'(m_alarm));
  endtask

  // Healthy comparator: flags (1,0) while injected, (0,1) otherwise.
  task automatic drive_pairs();
    int j;
    for (int i = 0; i < NUM_CH; i++) begin
      if (force_en[i]) begin
        ERR_DCLS[i] = force_err[i]; ERR_DCLS_B[i] = force_errb[i];
      end else if (FIERR_DCLS[i] && !stuck[i]) begin
        ERR_DCLS[i] = 1'b1; ERR_DCLS_B[i] = 1'b0;
      end else begin
        ERR_DCLS[i] = 1'b0; ERR_DCLS_B[i] = 1'b1;
      end
    end
    if (noise_pct > 0 && $urandom_range(0, 99) < noise_pct) begin
      j = $urandom_range(0, NUM_CH - 1);
      {ERR_DCLS[j], ERR_DCLS_B[j]} = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic tick(input string where);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(where);
    drive_pairs();
  endtask

  task automatic ticks(input int n, input string where);
    for (int i = 0; i < n; i++) tick(where);
  endtask

  task automatic pulse_start();
    START = 1'b1; tick("start"); START = 1'b0;
  endtask

  task automatic pulse_clr();
    CLR_STATUS = 1'b1; tick("clr"); CLR_STATUS = 1'b0;
  endtask

  // Called just after a checked edge: reset must clear outputs without a clock.
  task automatic async_reset(input string where);
    RESETN = 1'b0;
    #1;
    model_reset();
    check_all(where);
    repeat (2) @(posedge CLK);
    #1;
    check_all({where, "_hold"});
    RESETN = 1'b1;
    drive_pairs();
  endtask

  initial begin
    int dn, rise1, rise2, done_t, busy_seen;
    bit prev_busy;
    RESETN = 1'b0; ENABLE = 1'b0; START = 1'b0; CLR_STATUS = 1'b0; PERIOD = '0;
    stuck = '0; force_en = '0; force_err = '0; force_errb = '0;
    ERR_DCLS = '0; ERR_DCLS_B = '1;
    #12;
    model_reset();
    check_all("reset");
    #5 RESETN = 1'b1;

    // Healthy sweep on software request.
    ENABLE = 1'b1;
    ticks(5, "warm");
    pulse_start();
    dn = 0;
    for (int i = 0; i < 45; i++) begin
      tick("sweep");
      dn += int'(BIST_DONE);
    end
    chk("done_once", 32'(dn), 32'd1);
    chk("healthy_fail", 32'(BIST_FAIL), 32'd0);
    chk("healthy_alarm", 32'(ALARM), 32'd0);

    // Channel 1 flag stuck at 0: self-test must catch it, alarm follows, clear removes it.
    stuck = 2'b10;
    pulse_start();
    ticks(45, "stuck");
    chk("stuck_fail", 32'(BIST_FAIL), 32'b10);
    chk("stuck_alarm", 32'(ALARM), 32'd1);
    stuck = '0;
    pulse_clr();
    tick("after_clr");
    chk("clr_fail", 32'(BIST_FAIL), 32'd0);
    chk("clr_alarm", 32'(ALARM), 32'd0);

    // Periodic sweeps.
    PERIOD = 16'd100;
    rise1 = -1; rise2 = -1; done_t = -1; prev_busy = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick("period");
      if (BIST_BUSY && !prev_busy) begin
        if (rise1 < 0) rise1 = i; else if (rise2 < 0) rise2 = i;
      end
      if (BIST_DONE && done_t < 0) done_t = i;
      prev_busy = BIST_BUSY;
    end
    chk("period_first", 32'(rise1), 32'd100);
    chk("period_second", 32'(rise2 - done_t), 32'd100);
    PERIOD = '0;
    busy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      tick("period_off");
      busy_seen += int'(BIST_BUSY);
    end
    chk("period_off_busy", 32'(busy_seen), 32'd0);

    // Real mismatch on channel 0 while channel 1 is under test; same pattern on ch1 is masked.
    pulse_start();
    ticks(SL + 2, "to_ch1");
    force_en = 2'b01; force_err = 2'b01; force_errb = 2'b00;
    drive_pairs();
    tick("mm_ch0");
    force_en = 2'b00;
    drive_pairs();
    tick("mm_ch0_post");
    chk("run_err_ch0", 32'(RUN_ERR), 32'b01);
    force_en = 2'b10; force_err = 2'b10; force_errb = 2'b00;
    drive_pairs();
    tick("mm_ch1");
    force_en = 2'b00;
    drive_pairs();
    ticks(30, "mm_rest");
    chk("run_err_masked", 32'(RUN_ERR), 32'b01);

    // Pair inconsistency on channel 0 while idle.
    pulse_clr();
    force_en = 2'b01; force_err = 2'b01; force_errb = 2'b01;
    drive_pairs();
    tick("incons");
    force_en = 2'b00;
    drive_pairs();
    tick("incons_post");
    chk("run_err_incons", 32'(RUN_ERR), 32'b01);

    // Abort at cycle 5 of channel 0 test.
    pulse_clr();
    stuck = 2'b01;
    pulse_start();
    ticks(4, "pre_abort");
    ENABLE = 1'b0;
    tick("abort");
    chk("abort_fierr", 32'(FIERR_DCLS), 32'd0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      tick("abort_rest");
      dn += int'(BIST_DONE);
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    chk("abort_fail", 32'(BIST_FAIL), 32'd0);
    stuck = '0;
    ENABLE = 1'b1;
    ticks(5, "reenable");

    // Randomized traffic.
    noise_pct = 3;
    for (int i = 0; i < 2500; i++) begin
      START      = ($urandom_range(0, 99) < 3);
      CLR_STATUS = ($urandom_range(0, 99) < 2);
      if (ENABLE ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0)) ENABLE = ~ENABLE;
      if ($urandom_range(0, 99) == 0)
        PERIOD = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(20, 90));
      if ($urandom_range(0, 99) < 2) stuck = 2'($urandom_range(0, 3));
      tick("rand");
    end
    START = 1'b0; CLR_STATUS = 1'b0; noise_pct = 0; stuck = '0; PERIOD = '0; ENABLE = 1'b1;
    drive_pairs();
    ticks(60, "drain");

    // Reset in the middle of a test window.
    pulse_start();
    ticks(7, "pre_reset");
    async_reset("reset_mid");
    ticks(3, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
